spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first). Drives cs_bar/sclk/mosi and samples miso.
//  One DATA_W-bit full-duplex transfer per start request, with a programmable sclk rate.
//  Bench/companion master for the SPI responder in uart_spi_top; shares its freq_control encoding.
//  Single clock domain; all outputs registered.
// PARAMETERS
//  DATA_W        8  bits per transfer (>=2)
//  CLK_DIV_BASE  4  sclk half-period H in clk cycles when freq_control=0 (>=1)
//  CS_SETUP      2  clk cycles from cs_bar fall to start of first sclk low phase (>=1)
//  CS_HOLD       2  clk cycles from last sclk fall to cs_bar rise (>=1)
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high reset
//  freq_control  in   2       H = CLK_DIV_BASE << freq_control; sampled only at start acceptance
//  tx_data       in   DATA_W  byte to send; sampled only at start acceptance
//  tx_start      in   1       start request, honoured only while tx_ready=1
//  tx_ready      out  1       1 = idle, can accept tx_start
//  rx_data       out  DATA_W  last received word; holds until next completion
//  rx_valid      out  1       1-cycle pulse when rx_data is updated
//  cs_bar        out  1       chip select, active low
//  sclk          out  1       serial clock, idles low
//  mosi          out  1       serial data out, MSB first
//  miso          in   1       serial data in
// BEHAVIOUR
//  Reset (any state, any cycle): next edge -> IDLE; cs_bar=1, sclk=0, mosi=0, tx_ready=1,
//   rx_valid=0, rx_data=0; in-flight transfer abandoned, no rx_valid.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//  IDLE: cs_bar=1, sclk=0, mosi=0, tx_ready=1. tx_start=1 -> latch tx_data, H; go SETUP.
//  SETUP: cs_bar=0, mosi=tx MSB, sclk=0, tx_ready=0; stay CS_SETUP cycles -> XFER.
//  XFER: per bit, sclk low H cycles, then high H cycles (period 2H).
//   - Rising sclk: miso captured into shift reg on the same clk edge that sets sclk=1.
//   - Falling sclk (not last bit): mosi advances to next bit on the same edge sclk goes to 0.
//   - After DATA_W high phases, sclk returns to 0 -> HOLD; mosi holds LSB.
//  HOLD: cs_bar=0, sclk=0 for CS_HOLD cycles -> IDLE; on that edge cs_bar=1, mosi=0,
//   rx_data<=shift reg, rx_valid=1 for exactly 1 cycle, tx_ready=1.
//  Timing: cs_bar falls 1 cycle after accepted tx_start; cs_bar low for
//   CS_SETUP + 2*H*DATA_W + CS_HOLD cycles (68 at defaults, freq_control=0).
//  tx_start while tx_ready=0: ignored, not queued. freq_control/tx_data changes mid-transfer: no effect.
//  Back-to-back: tx_start=1 in the rx_valid cycle is accepted; cs_bar is high for exactly 1 cycle.
//  Bit counter width is clog2(DATA_W+1); divider counter must hold CLK_DIV_BASE<<3 without wrap.
// TESTING
//  1. reset=1 for 2 cycles -> cs_bar=1, sclk=0, mosi=0, tx_ready=1, rx_valid=0, rx_data=0.
//  2. Loopback miso=mosi, tx_data=0xA5, freq 0 -> mosi 1,0,1,0,0,1,0,1 on 8 rises 8 clk apart,
//     cs_bar low 68 cycles, rx_data=0xA5, single rx_valid pulse.
//  3. freq_control=3, tx 0x3C; set freq_control=0 mid-transfer -> sclk period stays 64 clk,
//     cs_bar low 2+512+2=516 cycles.
//  4. miso tied 1, tx 0x00; pulse tx_start with 0xFF mid-transfer -> mosi all 0, rx_data=0xFF,
//     only one rx_valid.
//  5. reset asserted after 3rd sclk rise -> idle values next cycle, no rx_valid; next transfer
//     0x5A loopback completes correctly.
//  6. tx_start held high, tx 0x81 then 0x7E -> two transfers, cs_bar high exactly 1 cycle
//     between, rx_data 0x81 then 0x7E.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one DATA_W-bit full-duplex transfer per accepted start request,
// MSB first, with sclk half-period CLK_DIV_BASE << freq_control clock cycles.
module spi_master_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLK_DIV_BASE = 4,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        freq_control,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              cs_bar,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int H_MAX   = CLK_DIV_BASE << 3;
  localparam int CS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (H_MAX > CS_MAX) ? H_MAX : CS_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  half_m1;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  // Transfer sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      half_m1  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cs_bar   <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state    <= SETUP;
            tx_ready <= 1'b0;
            cs_bar   <= 1'b0;
            mosi     <= tx_data[DATA_W-1];
            tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            half_m1  <= (CNT_W'(CLK_DIV_BASE) << freq_control) - CNT_W'(1);
            cnt      <= CNT_W'(CS_SETUP - 1);
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(0)) begin
            state <= XFER;
            cnt   <= half_m1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        XFER: begin
          if (cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!sclk) begin
            // Rising edge: sample miso together with raising sclk.
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
            cnt      <= half_m1;
          end else begin
            sclk <= 1'b0;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state <= HOLD;
              cnt   <= CNT_W'(CS_HOLD - 1);
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              mosi     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              cnt      <= half_m1;
            end
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(0)) begin
            state    <= IDLE;
            cs_bar   <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            tx_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          cs_bar   <= 1'b1;
          sclk     <= 1'b0;
          mosi     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: expected transfers are queued at start and
// checked by a negedge monitor when rx_valid fires.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] freq_control;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs_bar;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       loopback;
  logic       miso_drv;

  assign miso = loopback ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_ctrl dut (
    .clk(clk), .reset(reset), .freq_control(freq_control), .tx_data(tx_data),
    .tx_start(tx_start), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .cs_bar(cs_bar), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi_bits;
    int         len;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int         cyc = 0;
  logic       mon_en = 1'b0;
  int         cs_lo = 0, cs_hi = 0, cs_hi_last = 0;
  int         rise_cnt = 0, last_rise = 0, exp_period = 8;
  int         rx_seen = 0;
  logic [7:0] mosi_word = 8'h00;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_rxv = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Negedge monitor: timing of cs_bar/sclk, mosi bit capture and scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!mon_en) begin
      cs_lo = 0; rise_cnt = 0; mosi_word = 8'h00;
    end else begin
      if (cs_bar == 1'b0) begin
        cs_lo++;
        if (prev_cs) cs_hi_last = cs_hi;
        cs_hi = 0;
      end else begin
        cs_hi++;
      end
      if (sclk && !prev_sclk) begin
        if (rise_cnt > 0) check_eq("sclk_period", cyc - last_rise, exp_period);
        last_rise = cyc;
        rise_cnt++;
        mosi_word = {mosi_word[6:0], mosi};
      end
      if (rx_valid) begin
        rx_seen++;
        check_eq("rx_pulse_prev", prev_rxv, 1'b0);
        if (sb.size() == 0) begin
          check_eq("rx_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("rx_data", rx_data, e.rx);
          check_eq("cs_low_len", cs_lo, e.len);
          check_eq("mosi_bits", mosi_word, e.mosi_bits);
          check_eq("rise_count", rise_cnt, 8);
        end
        cs_lo = 0; rise_cnt = 0; mosi_word = 8'h00;
      end
    end
    prev_cs = cs_bar; prev_sclk = sclk; prev_rxv = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    if (tx_ready !== 1'b1) check_eq("timeout_ready", tx_ready, 1'b1);
  endtask

  task automatic wait_rx(input int target, input int budget);
    int k;
    k = 0;
    while (rx_seen < target && k < budget) begin
      tick(1);
      k++;
    end
    if (rx_seen < target) check_eq("timeout_rx", rx_seen, target);
  endtask

  task automatic push_exp(input logic [7:0] rx, input logic [7:0] mb, input logic [1:0] f);
    exp_t e;
    int h;
    h = 4 << f;
    e.rx = rx; e.mosi_bits = mb; e.len = 2 + 2 * h * 8 + 2;
    sb.push_back(e);
    exp_period = 2 * h;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] f, input logic [7:0] rx);
    wait_ready(2000);
    tx_data = d; freq_control = f; tx_start = 1'b1;
    push_exp(rx, d, f);
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    tick(2);
    check_eq("rst_cs_bar", cs_bar, 1'b1);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_tx_ready", tx_ready, 1'b1);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    sb.delete();
    tick(1);
    mon_en = 1'b1;
  endtask

  initial begin
    int base;
    int k;
    reset = 1'b1; freq_control = 2'd0; tx_data = 8'h00; tx_start = 1'b0;
    loopback = 1'b1; miso_drv = 1'b0;

    // 1. reset state
    do_reset();

    // 2. loopback 0xA5 at the fastest rate
    base = rx_seen;
    send(8'hA5, 2'd0, 8'hA5);
    wait_rx(base + 1, 500);
    tick(20);
    check_eq("t2_single_rx", rx_seen - base, 1);

    // 3. slowest rate; freq_control change mid-transfer has no effect
    base = rx_seen;
    send(8'h3C, 2'd3, 8'h3C);
    tick(100);
    freq_control = 2'd0;
    wait_rx(base + 1, 2000);

    // 4. miso tied high, ignored start request mid-transfer
    loopback = 1'b0; miso_drv = 1'b1;
    base = rx_seen;
    send(8'h00, 2'd0, 8'hFF);
    tick(20);
    tx_data = 8'hFF; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    wait_rx(base + 1, 500);
    tick(100);
    check_eq("t4_single_rx", rx_seen - base, 1);
    check_eq("t4_idle_ready", tx_ready, 1'b1);
    loopback = 1'b1;

    // 5. reset after the 3rd sclk rise abandons the transfer
    base = rx_seen;
    send(8'h33, 2'd0, 8'h33);
    k = 0;
    while (rise_cnt < 3 && k < 200) begin
      tick(1);
      k++;
    end
    if (rise_cnt < 3) check_eq("timeout_rise3", rise_cnt, 3);
    do_reset();
    check_eq("t5_no_rx", rx_seen - base, 0);
    send(8'h5A, 2'd0, 8'h5A);
    wait_rx(base + 1, 500);

    // 6. back-to-back with tx_start held high
    wait_ready(500);
    base = rx_seen;
    tx_data = 8'h81; freq_control = 2'd0; tx_start = 1'b1;
    push_exp(8'h81, 8'h81, 2'd0);
    push_exp(8'h7E, 8'h7E, 2'd0);
    tick(1);
    tx_data = 8'h7E;
    wait_rx(base + 1, 500);
    tx_start = 1'b0;
    wait_rx(base + 2, 500);
    check_eq("t6_cs_high_gap", cs_hi_last, 1);
    tick(20);
    check_eq("t6_rx_count", rx_seen - base, 2);
    check_eq("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
